spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 8, giving the frame length in bits.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on sclk, nss and mosi.
REQ-003 The block SHALL have port clk  in  1  system clock, the only clock in the block.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port sclk  in  1  SPI clock driven by the master, asynchronous to clk.
REQ-006 The block SHALL have port nss  in  1  slave select, active-low, asynchronous to clk.
REQ-007 The block SHALL have port mosi  in  1  master-out data, asynchronous to clk.
REQ-008 The block SHALL have port miso  out  1  slave-out data.
REQ-009 The block SHALL have port miso_oe  out  1  miso output enable, high while a frame is active.
REQ-010 The block SHALL have port cpol  in  1  SPI clock idle level.
REQ-011 The block SHALL have port cpha  in  1  SPI clock phase: 0 samples on the leading edge, 1 on the trailing edge.
REQ-012 The block SHALL have port lsbf  in  1  bit order: 1 means LSB first.
REQ-013 The block SHALL have port wdata  in  BIT_WIDTH  transmit word.
REQ-014 The block SHALL have port rdata  out  BIT_WIDTH  last received word.
REQ-015 The block SHALL have port rx_valid  out  1  single-cycle pulse on word completion.
REQ-016 The block SHALL have port busy  out  1  high while the state is ACTIVE.

Function
REQ-017 sclk, nss and mosi SHALL pass through SYNC_STAGES flops; edges are detected on the synchronized signals.
REQ-018 Correct operation SHALL be guaranteed for sclk half-period >= 4 clk cycles.
REQ-019 Leading edge SHALL be the sclk transition away from cpol; trailing edge is the transition back to cpol.
REQ-020 The FSM SHALL have states IDLE and ACTIVE.
REQ-021 IDLE->ACTIVE SHALL occur on a synchronized nss falling edge; in that cycle the block loads wdata into the tx shift register and clears the bit counter.
REQ-022 cpha=0: the first tx bit SHALL be on miso by the end of the nss-fall cycle; sample mosi on leading edges; shift the next tx bit on trailing edges.
REQ-023 cpha=1: the block SHALL shift a tx bit onto miso on leading edges and sample mosi on trailing edges.
REQ-024 lsbf=0 SHALL transmit and assemble MSB first; lsbf=1 SHALL transmit and assemble LSB first.
REQ-025 cpol, cpha and lsbf SHALL be captured at the nss-fall cycle and held constant for the whole frame.
REQ-026 The bit counter SHALL count samples 0..BIT_WIDTH-1.
REQ-027 The cycle after the BIT_WIDTH-th sample, the block SHALL update rdata, pulse rx_valid for exactly 1 cycle, wrap the counter to 0 and reload wdata if nss is still low (back-to-back words).
REQ-028 A synchronized nss rise in ACTIVE SHALL return the block to IDLE; a partial word is discarded, with no rx_valid and rdata unchanged.
REQ-029 If nss rises in the same cycle as the final sample, the block SHALL complete the word (rx_valid pulses) and then go to IDLE.
REQ-030 sclk edges SHALL be ignored in IDLE.
REQ-031 miso_oe SHALL equal busy; miso SHALL be 0 whenever miso_oe is 0.
REQ-032 rdata SHALL hold its value until the next completed word.

Reset
REQ-033 When rst is high at a clk edge, the state SHALL become IDLE and miso, miso_oe, rx_valid, busy, rdata, the counter, the shift registers and the synchronizers SHALL become 0.
REQ-034 A reset mid-frame SHALL abort the frame.
REQ-035 After reset, the block SHALL wait for a fresh nss fall; if nss is already low at reset release, it does not start.

Configuration
REQ-036 When SPI_SLAVE_OVR_EN is defined, the block SHALL add port rx_ack  in  1  (consumer read acknowledge) and port ovr  out  1  (sticky overrun flag).
REQ-037 With SPI_SLAVE_OVR_EN, a pending flag SHALL set on rx_valid and clear on rx_ack.
REQ-038 With SPI_SLAVE_OVR_EN, rx_valid while pending is set and rx_ack is low SHALL set ovr; ovr clears only on rst.
REQ-039 With SPI_SLAVE_OVR_EN, simultaneous rx_ack and rx_valid SHALL leave pending set and SHALL NOT set ovr.
REQ-040 Without SPI_SLAVE_OVR_EN, neither port SHALL exist and no pending or overrun logic SHALL be present.

Structure
REQ-041 Package spi_pkg SHALL hold the state enum (IDLE, ACTIVE) and the mode typedef {cpol, cpha, lsbf}, shared with spi_master_debug.
REQ-042 Sub-module spi_sync SHALL be a parameterized N-stage synchronizer with rising and falling edge outputs, instantiated for sclk, nss and mosi.

Verification
REQ-043 Mode 0, MSB first, wdata=8'hA5, master sends 8'h12: rdata=8'h12, rx_valid pulses once, master receives 8'hA5.
REQ-044 Each of the 4 cpol/cpha modes with lsbf=1, master sends 8'h56 then 8'h78 within one nss-low window, wdata=8'h3C: rdata=8'h56 then 8'h78, 2 rx_valid pulses, master receives 8'h3C twice.
REQ-045 nss rises after 3 sclk edges in mode 0: no rx_valid, rdata keeps its prior value, busy falls within SYNC_STAGES+1 cycles.
REQ-046 rst asserted for 1 cycle mid-frame: all outputs are 0 the next cycle; the following full frame with 8'h34 gives rdata=8'h34.
REQ-047 With SPI_SLAVE_OVR_EN, 2 words and no rx_ack: ovr=1 after the second rx_valid; repeating with rx_ack pulsed between the words keeps ovr=0.
REQ-048 The master (spi_master_debug, CLK_DIV=20) in mode 3 at 50 MHz sends 8'hFF: rdata=8'hFF and miso matches wdata bit-by-bit.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI types: slave FSM state and the per-frame mode word.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsbf;
  } spi_mode_t;

endpackage

// File: rtl/spi_sync.sv
// N-stage synchronizer with edge detection on the synchronized level.
module spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_r;
  logic              prev_r;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
      prev_r <= sync_r[STAGES-1];
    end
  end

  assign q    = sync_r[STAGES-1];
  assign rise = sync_r[STAGES-1] & ~prev_r;
  assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four cpol/cpha modes, MSB/LSB first, back-to-back words.
// Define SPI_SLAVE_OVR_EN to add rx_ack/ovr overrun detection.
module spi_slave
  import spi_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 nss,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsbf,
  input  logic [BIT_WIDTH-1:0] wdata,
  output logic [BIT_WIDTH-1:0] rdata,
  output logic                 rx_valid,
  output logic                 busy
`ifdef SPI_SLAVE_OVR_EN
  ,
  input  logic                 rx_ack,
  output logic                 ovr
`endif
);

  localparam int CW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_WIDTH - 1);

  function automatic logic first_bit(input logic [BIT_WIDTH-1:0] w, input logic lsb_first);
    return lsb_first ? w[0] : w[BIT_WIDTH-1];
  endfunction

  function automatic logic [BIT_WIDTH-1:0] shift_out(input logic [BIT_WIDTH-1:0] w,
                                                     input logic lsb_first);
    return lsb_first ? (w >> 1'b1) : (w << 1'b1);
  endfunction

  function automatic logic [BIT_WIDTH-1:0] shift_in(input logic [BIT_WIDTH-1:0] w,
                                                    input logic b, input logic lsb_first);
    return lsb_first ? {b, w[BIT_WIDTH-1:1]} : {w[BIT_WIDTH-2:0], b};
  endfunction

  logic sclk_lvl_unused_s, sclk_rise_s, sclk_fall_s;
  logic nss_q_s, nss_rise_s, nss_fall_s;
  logic mosi_s, mosi_rise_unused_s, mosi_fall_unused_s;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_lvl_unused_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_nss (
    .clk(clk), .rst(rst), .d(nss), .q(nss_q_s), .rise(nss_rise_s), .fall(nss_fall_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused_s), .fall(mosi_fall_unused_s)
  );

  spi_state_e           state_r, state_n;
  spi_mode_t            mode_r;
  logic [BIT_WIDTH-1:0] tx_shift_r, rx_shift_r, rdata_r;
  logic [CW-1:0]        cnt_r;
  logic                 complete_r, miso_r, busy_r, rx_valid_r;
  logic                 lead_s, trail_s, sample_edge_s, shift_edge_s;
  logic                 start_s, sample_s, shift_s, reload_s;

  assign lead_s        = mode_r.cpol ? sclk_fall_s : sclk_rise_s;
  assign trail_s       = mode_r.cpol ? sclk_rise_s : sclk_fall_s;
  assign sample_edge_s = mode_r.cpha ? trail_s : lead_s;
  assign shift_edge_s  = mode_r.cpha ? lead_s : trail_s;
  assign reload_s      = complete_r && (state_r == ACTIVE) && !nss_q_s;

  // Next-state and per-cycle action strobes
  always_comb begin
    state_n  = state_r;
    start_s  = 1'b0;
    sample_s = 1'b0;
    shift_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (nss_fall_s) begin
          state_n = ACTIVE;
          start_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      ACTIVE: begin
        sample_s = sample_edge_s;
        // cpha=0: the trailing edge after a word's last sample must not disturb the reloaded word
        shift_s  = shift_edge_s && (mode_r.cpha || (cnt_r != CW'(0)));
        if (nss_rise_s) begin
          state_n = IDLE;
        end else begin
          state_n = ACTIVE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, shift registers, bit counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      mode_r     <= 3'b000;
      tx_shift_r <= {BIT_WIDTH{1'b0}};
      rx_shift_r <= {BIT_WIDTH{1'b0}};
      rdata_r    <= {BIT_WIDTH{1'b0}};
      cnt_r      <= {CW{1'b0}};
      complete_r <= 1'b0;
      miso_r     <= 1'b0;
      busy_r     <= 1'b0;
      rx_valid_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      busy_r     <= (state_n == ACTIVE);
      rx_valid_r <= 1'b0;
      if (start_s) begin
        mode_r     <= {cpol, cpha, lsbf};
        cnt_r      <= {CW{1'b0}};
        complete_r <= 1'b0;
        if (cpha) begin
          tx_shift_r <= wdata;
          miso_r     <= 1'b0;
        end else begin
          tx_shift_r <= shift_out(wdata, lsbf);
          miso_r     <= first_bit(wdata, lsbf);
        end
      end else begin
        if (sample_s) begin
          rx_shift_r <= shift_in(rx_shift_r, mosi_s, mode_r.lsbf);
          if (cnt_r == LAST_CNT) begin
            complete_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        if (complete_r) begin
          rdata_r    <= rx_shift_r;
          rx_valid_r <= 1'b1;
          cnt_r      <= {CW{1'b0}};
          complete_r <= 1'b0;
        end
        if (reload_s) begin
          if (mode_r.cpha) begin
            tx_shift_r <= wdata;
          end else begin
            tx_shift_r <= shift_out(wdata, mode_r.lsbf);
            miso_r     <= first_bit(wdata, mode_r.lsbf);
          end
        end else if (shift_s) begin
          miso_r     <= first_bit(tx_shift_r, mode_r.lsbf);
          tx_shift_r <= shift_out(tx_shift_r, mode_r.lsbf);
        end
        if (state_n == IDLE) begin
          miso_r <= 1'b0;
        end
      end
    end
  end

  assign miso     = miso_r;
  assign miso_oe  = busy_r;
  assign busy     = busy_r;
  assign rdata    = rdata_r;
  assign rx_valid = rx_valid_r;

`ifdef SPI_SLAVE_OVR_EN
  logic pending_r, ovr_r;

  // Unread-word tracking; a new word over an unread one is a sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      if (rx_valid_r) begin
        pending_r <= 1'b1;
      end else if (rx_ack) begin
        pending_r <= 1'b0;
      end
      if (rx_valid_r && pending_r && !rx_ack) begin
        ovr_r <= 1'b1;
      end
    end
  end

  assign ovr = ovr_r;
`endif

endmodule
